// File: rtl/rs485_frame_pkg.sv
// Shared constants for the RS485 command-frame receiver: FSM state codes,
// error codes and default frame parameters.
package rs485_frame_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] err_code_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_CMD  = 3'd2;
  localparam state_t ST_ARG  = 3'd3;
  localparam state_t ST_CHK  = 3'd4;

  localparam err_code_t ERR_NONE = 2'b00;
  localparam err_code_t ERR_CHK  = 2'b01;
  localparam err_code_t ERR_TMO  = 2'b10;

  localparam logic [7:0]  HEADER_DEFAULT      = 8'hA5;
  localparam logic [7:0]  NODE_ADDR_DEFAULT   = 8'h01;
  localparam logic [7:0]  ADDR_BCAST          = 8'hFF;
  localparam logic [17:0] TIMEOUT_MAX_DEFAULT = 18'd156_249;

endpackage

// File: rtl/rs485_byte_timer.sv
// Inter-byte idle timer: counts clocks while enabled and flags when the count
// reaches TIMEOUT_MAX. The count saturates there until cleared.
module rs485_byte_timer
  import rs485_frame_pkg::*;
#(
  parameter logic [17:0] TIMEOUT_MAX = TIMEOUT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [17:0] count_q;
  logic [17:0] count_d;

  assign expired = (count_q == TIMEOUT_MAX);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 18'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rs485_frame_rx.sv
// RS485 command-frame parser: HDR,CMD,ARG,CHK (or HDR,ADDR,CMD,ARG,CHK when
// RS485_FRAME_ADDR_EN is defined) with checksum and inter-byte timeout errors.
module rs485_frame_rx
  import rs485_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
`ifdef RS485_FRAME_ADDR_EN
  parameter logic [7:0]  NODE_ADDR   = NODE_ADDR_DEFAULT,
`endif
  parameter logic [17:0] TIMEOUT_MAX = TIMEOUT_MAX_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       cmd_valid,
  output logic       err_flag,
  output logic [1:0] err_code
);

`ifdef RS485_FRAME_ADDR_EN
  localparam state_t ST_FIRST = ST_ADDR;
`else
  localparam state_t ST_FIRST = ST_CMD;
`endif

  state_t     state_q, state_d;
  logic [7:0] cmd_r_q, cmd_r_d;
  logic [7:0] arg_r_q, arg_r_d;
  logic [7:0] sum_q, sum_d;
  logic       addr_ok_q, addr_ok_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] arg_q, arg_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       err_flag_q, err_flag_d;
  err_code_t  err_code_q, err_code_d;
  logic       tmr_expired;

  // Timer only runs inside a frame; every accepted byte restarts it.
  rs485_byte_timer #(
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (pi_flag || (state_q == ST_IDLE)),
    .en       (state_q != ST_IDLE),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_r_d     = cmd_r_q;
    arg_r_d     = arg_r_q;
    sum_d       = sum_q;
    addr_ok_d   = addr_ok_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    cmd_valid_d = 1'b0;
    err_flag_d  = 1'b0;
    err_code_d  = err_code_q;
    if (pi_flag) begin
      case (state_q)
        ST_IDLE: begin
          if (pi_data == HEADER) begin
            state_d   = ST_FIRST;
            sum_d     = 8'h00;
            addr_ok_d = 1'b1;
          end
        end
`ifdef RS485_FRAME_ADDR_EN
        ST_ADDR: begin
          addr_ok_d = (pi_data == NODE_ADDR) || (pi_data == ADDR_BCAST);
          sum_d     = sum_q + pi_data;
          state_d   = ST_CMD;
        end
`endif
        ST_CMD: begin
          cmd_r_d = pi_data;
          sum_d   = sum_q + pi_data;
          state_d = ST_ARG;
        end
        ST_ARG: begin
          arg_r_d = pi_data;
          sum_d   = sum_q + pi_data;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          // Frames for other nodes are consumed without any strobe.
          if (addr_ok_q) begin
            if (pi_data == sum_q) begin
              cmd_d       = cmd_r_q;
              arg_d       = arg_r_q;
              cmd_valid_d = 1'b1;
            end else begin
              err_flag_d = 1'b1;
              err_code_d = ERR_CHK;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && tmr_expired) begin
      state_d    = ST_IDLE;
      err_flag_d = 1'b1;
      err_code_d = ERR_TMO;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_r_q     <= 8'h00;
      arg_r_q     <= 8'h00;
      sum_q       <= 8'h00;
      addr_ok_q   <= 1'b0;
      cmd_q       <= 8'h00;
      arg_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cmd_r_q     <= cmd_r_d;
      arg_r_q     <= arg_r_d;
      sum_q       <= sum_d;
      addr_ok_q   <= addr_ok_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      cmd_valid_q <= cmd_valid_d;
      err_flag_q  <= err_flag_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd       = cmd_q;
  assign arg       = arg_q;
  assign cmd_valid = cmd_valid_q;
  assign err_flag  = err_flag_q;
  assign err_code  = err_code_q;

endmodule
